bcd_digit_adder: RTL and testbench



---
 rtl/bcd_digit_adder.sv | 87 ++++++++
 tb/tb_bcd_digit_adder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_adder.sv
// ---------------------------------------------------------------------------
// bcd_digit_adder
//
// Single-digit BCD adder with registered outputs. Adds two BCD digits plus a
// decimal carry-in, applies decimal correction and registers one BCD sum
// digit and a decimal carry-out. Operands above 9 are flagged on err, and
// for them the sum and carry are forced to zero. Latency is one cycle.
// Cascade digits through cin/cout: each stage adds one cycle of delay.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous reset, active-high; clears s/cout/err
//   a    - BCD operand digit (legal 0..9)
//   b    - BCD operand digit (legal 0..9)
//   cin  - decimal carry-in
//   s    - registered BCD sum digit (0..9)
//   cout - registered decimal carry-out (tens digit of a+b+cin)
//   err  - registered flag, set when a or b exceeds 9
// ---------------------------------------------------------------------------
module bcd_digit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       err
);

  // True when a 4-bit value is a legal BCD digit.
  function automatic logic is_bcd(input logic [3:0] digit);
    is_bcd = (digit <= 4'd9);
  endfunction

  logic [4:0] bin_s;       // binary sum, at most 31, so 5 bits never overflow
  logic [4:0] corr_s;      // binary sum plus 6; its low nibble is bin - 10
  logic       invalid_s;
  logic [3:0] s_d;
  logic       cout_d;
  logic       err_d;
  logic [3:0] s_q;
  logic       cout_q;
  logic       err_q;

  // Binary add, validity check and decimal correction feeding the registers.
  always_comb begin
    bin_s     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    corr_s    = bin_s + 5'd6;
    invalid_s = ~(is_bcd(a) & is_bcd(b));
    s_d       = 4'd0;
    cout_d    = 1'b0;
    err_d     = 1'b0;
    if (invalid_s) begin
      // No correction is attempted for non-BCD operands.
      s_d    = 4'd0;
      cout_d = 1'b0;
      err_d  = 1'b1;
    end else if (bin_s >= 5'd10) begin
      s_d    = corr_s[3:0];
      cout_d = 1'b1;
      err_d  = 1'b0;
    end else begin
      s_d    = bin_s[3:0];
      cout_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  // Output registers; reset takes priority over capturing a new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 4'd0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      err_q  <= err_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_digit_adder.sv
module tb_bcd_digit_adder;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       err;

  int total;
  int bad;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       rst;
    logic [3:0] s;
    logic       cout;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       err;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       rst;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[18];

  bcd_digit_adder dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal arithmetic, independent of the binary+6 trick.
  function automatic exp_t model(input logic [3:0] va, input logic [3:0] vb,
                                 input logic vcin, input logic vrst);
    exp_t e;
    int   sum;
    e.a = va; e.b = vb; e.cin = vcin; e.rst = vrst;
    if (vrst) begin
      e.s = 4'd0; e.cout = 1'b0; e.err = 1'b0;
    end else if (va > 4'd9 || vb > 4'd9) begin
      e.s = 4'd0; e.cout = 1'b0; e.err = 1'b1;
    end else begin
      sum    = int'(va) + int'(vb) + int'(vcin);
      e.s    = 4'(sum % 10);
      e.cout = (sum >= 10);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic check_one(input string name);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got s=%0d cout=%0d err=%0d", name, s, cout, err);
    end else begin
      e = exp_q.pop_front();
      if (s !== e.s || cout !== e.cout || err !== e.err) begin
        bad++;
        $display("FAIL %s: a=%0d b=%0d cin=%0d rst=%0d got s=%0d cout=%0d err=%0d want s=%0d cout=%0d err=%0d",
                 name, e.a, e.b, e.cin, e.rst, s, cout, err, e.s, e.cout, e.err);
      end
    end
  endtask

  // Drive one vector before an edge, record expectation, check 1 after edge.
  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vcin,
                       input logic vrst, input exp_t e, input string name);
    @(negedge clk);
    a = va; b = vb; cin = vcin; rst = vrst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_one(name);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b1;

    //               a      b      cin   rst   s      cout  err
    tbl[0]  = '{4'd9,  4'd9,  1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'd9,  4'd9,  1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{4'd9,  4'd9,  1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
    tbl[3]  = '{4'd5,  4'd4,  1'b0, 1'b0, 4'd9, 1'b0, 1'b0};
    tbl[4]  = '{4'd0,  4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{4'd5,  4'd5,  1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[6]  = '{4'd4,  4'd5,  1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[7]  = '{4'd7,  4'd8,  1'b1, 1'b0, 4'd6, 1'b1, 1'b0};
    tbl[8]  = '{4'd12, 4'd3,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{4'd9,  4'd15, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[10] = '{4'd2,  4'd3,  1'b0, 1'b0, 4'd5, 1'b0, 1'b0};
    tbl[11] = '{4'd9,  4'd9,  1'b0, 1'b0, 4'd8, 1'b1, 1'b0};
    tbl[12] = '{4'd10, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[13] = '{4'd0,  4'd10, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[14] = '{4'd15, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[15] = '{4'd0,  4'd0,  1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[16] = '{4'd9,  4'd0,  1'b0, 1'b0, 4'd9, 1'b0, 1'b0};
    tbl[17] = '{4'd9,  4'd0,  1'b1, 1'b0, 4'd0, 1'b1, 1'b0};

    // Directed table, back to back, starting with two reset edges.
    for (int i = 0; i < 18; i++) begin
      exp_t e;
      e.a = tbl[i].a; e.b = tbl[i].b; e.cin = tbl[i].cin; e.rst = tbl[i].rst;
      e.s = tbl[i].s; e.cout = tbl[i].cout; e.err = tbl[i].err;
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].rst, e, $sformatf("table[%0d]", i));
    end

    // Exhaustive legal operand space, one vector per cycle.
    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 10; x++) begin
        for (int y = 0; y < 10; y++) begin
          drive(4'(x), 4'(y), 1'(c), 1'b0, model(4'(x), 4'(y), 1'(c), 1'b0), "exhaustive");
        end
      end
    end

    // Reset asserted for one edge in the middle of a stream.
    drive(4'd8, 4'd7, 1'b0, 1'b0, model(4'd8, 4'd7, 1'b0, 1'b0), "pre_rst");
    drive(4'd9, 4'd9, 1'b1, 1'b1, model(4'd9, 4'd9, 1'b1, 1'b1), "mid_rst");
    drive(4'd13, 4'd1, 1'b0, 1'b0, model(4'd13, 4'd1, 1'b0, 1'b0), "post_rst_inv");
    drive(4'd6, 4'd6, 1'b1, 1'b0, model(4'd6, 4'd6, 1'b1, 1'b0), "post_rst");

    // Random back-to-back traffic across the full 4-bit range.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] ra, rb;
      logic       rc, rr;
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      rc = 1'($urandom_range(1, 0));
      rr = ($urandom_range(19, 0) == 0);
      drive(ra, rb, rc, rr, model(ra, rb, rc, rr), "random");
    end

    // Outputs must hold between edges while inputs change mid-cycle.
    drive(4'd3, 4'd4, 1'b0, 1'b0, model(4'd3, 4'd4, 1'b0, 1'b0), "hold_setup");
    @(negedge clk);
    a = 4'd9; b = 4'd9; cin = 1'b1;
    #1;
    total++;
    if (s !== 4'd7 || cout !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL hold: got s=%0d cout=%0d err=%0d want s=7 cout=0 err=0", s, cout, err);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
